// File: rtl/array_mul.sv
// Sequential unsigned N x N array multiplier.
// Operands are captured while en is low. While en is high, one shifted
// partial-product row is added into the 2N-bit accumulator per clock, so
// the full product appears N run edges after en rises. The accumulator is
// driven straight onto p, which lets intermediate partial sums be observed.
module array_mul #(
  parameter int N = 4
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           en,
  input  logic [N-1:0]   a,
  input  logic [N-1:0]   b,
  output logic [2*N-1:0] p,
  output logic           done
);

  // Row counter only has to reach N-1; N >= 2 keeps this width at least 1.
  localparam int RW = (N > 1) ? $clog2(N) : 1;
  localparam logic [RW-1:0] LAST_ROW = RW'(N - 1);

  logic [N-1:0]   a_q,    a_d;
  logic [N-1:0]   b_q,    b_d;
  logic [2*N-1:0] p_q,    p_d;
  logic [RW-1:0]  row_q,  row_d;
  logic           done_q, done_d;
  logic [2*N-1:0] row_term_s;

  // Next-state selection: load operands, add one row, or hold the result.
  always_comb begin
    a_d    = a_q;
    b_d    = b_q;
    p_d    = p_q;
    row_d  = row_q;
    done_d = done_q;

    // Current row: multiplicand gated by one multiplier bit, moved to its
    // binary weight. Zero-extended first so the shift never loses bits.
    row_term_s = {{N{1'b0}}, a_q & {N{b_q[row_q]}}} << row_q;

    if (!en) begin
      // Load / restart: also serves as the abort path mid-multiply.
      a_d    = a;
      b_d    = b;
      p_d    = {(2*N){1'b0}};
      row_d  = {RW{1'b0}};
      done_d = 1'b0;
    end else if (!done_q) begin
      // Run: the 2N-bit accumulator cannot overflow for N-bit operands.
      p_d   = p_q + row_term_s;
      row_d = row_q + RW'(1);
      if (row_q == LAST_ROW) begin
        done_d = 1'b1;
      end else begin
        done_d = 1'b0;
      end
    end else begin
      // Hold: the finished product stays put until en drops.
      p_d    = p_q;
      row_d  = row_q;
      done_d = 1'b1;
    end
  end

  // State registers with synchronous reset taking priority over en.
  always_ff @(posedge clk) begin
    if (rst) begin
      a_q    <= {N{1'b0}};
      b_q    <= {N{1'b0}};
      p_q    <= {(2*N){1'b0}};
      row_q  <= {RW{1'b0}};
      done_q <= 1'b0;
    end else begin
      a_q    <= a_d;
      b_q    <= b_d;
      p_q    <= p_d;
      row_q  <= row_d;
      done_q <= done_d;
    end
  end

  assign p    = p_q;
  assign done = done_q;

endmodule

// File: tb/tb_array_mul.sv
// Scoreboard bench for array_mul: a 4-bit and an 8-bit instance are driven
// with directed vectors; each stimulus cycle pushes its expected p/done into
// a queue and an independent monitor pops and compares on the falling edge.
module tb_array_mul;

  logic        clk;
  logic        rst;
  logic        en4;
  logic [3:0]  a4;
  logic [3:0]  b4;
  logic [7:0]  p4;
  logic        done4;
  logic        en8;
  logic [7:0]  a8;
  logic [7:0]  b8;
  logic [15:0] p8;
  logic        done8;

  typedef struct {
    bit          wide;
    logic [15:0] p;
    logic        done;
    string       nm;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp;
  int   n_bad;

  array_mul #(.N(4)) dut4 (
    .clk (clk), .rst (rst), .en (en4), .a (a4), .b (b4), .p (p4), .done (done4)
  );

  array_mul #(.N(8)) dut8 (
    .clk (clk), .rst (rst), .en (en8), .a (a8), .b (b8), .p (p8), .done (done8)
  );

  // Free-running clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // One cycle on the 4-bit instance, then queue the expected post-edge state.
  task automatic step4(input logic e, input logic [3:0] aa, input logic [3:0] bb,
                       input logic [7:0] ep, input logic ed, input string nm);
    exp_t x;
    @(negedge clk);
    rst = 1'b0;
    en4 = e;
    a4  = aa;
    b4  = bb;
    @(posedge clk);
    x.wide = 1'b0;
    x.p    = {8'd0, ep};
    x.done = ed;
    x.nm   = nm;
    exp_q.push_back(x);
  endtask

  // One cycle on the 8-bit instance, then queue the expected post-edge state.
  task automatic step8(input logic e, input logic [7:0] aa, input logic [7:0] bb,
                       input logic [15:0] ep, input logic ed, input string nm);
    exp_t x;
    @(negedge clk);
    rst = 1'b0;
    en8 = e;
    a8  = aa;
    b8  = bb;
    @(posedge clk);
    x.wide = 1'b1;
    x.p    = ep;
    x.done = ed;
    x.nm   = nm;
    exp_q.push_back(x);
  endtask

  // Monitor: compare every queued expectation against the live outputs.
  initial begin
    exp_t        x;
    logic [15:0] act_p;
    logic        act_d;
    n_cmp = 0;
    n_bad = 0;
    forever begin
      @(negedge clk);
      while (exp_q.size() > 0) begin
        x     = exp_q.pop_front();
        act_p = x.wide ? p8 : {8'd0, p4};
        act_d = x.wide ? done8 : done4;
        n_cmp = n_cmp + 1;
        if (act_p !== x.p || act_d !== x.done) begin
          n_bad = n_bad + 1;
          $display("FAIL %s: got p=%0d done=%b, want p=%0d done=%b",
                   x.nm, act_p, act_d, x.p, x.done);
        end
      end
    end
  end

  // Directed stimulus.
  initial begin
    logic [15:0] wide_exp[8];
    exp_t        x;
    wide_exp = '{16'd255, 16'd765, 16'd1785, 16'd3825,
                 16'd7905, 16'd16065, 16'd32385, 16'd65025};

    rst = 1'b1;
    en4 = 1'b1; a4 = 4'd15;  b4 = 4'd15;
    en8 = 1'b1; a8 = 8'd255; b8 = 8'd255;

    // Reset held for two cycles with en high and full-scale operands.
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      rst = 1'b1;
      @(posedge clk);
      x.wide = 1'b0; x.p = 16'd0; x.done = 1'b0; x.nm = "reset_n4";
      exp_q.push_back(x);
      x.wide = 1'b1; x.nm = "reset_n8";
      exp_q.push_back(x);
    end
    en8 = 1'b0;

    // 1 x 1: final after first run edge, done after the fourth.
    step4(1'b0, 4'd1, 4'd1, 8'd0, 1'b0, "load_1x1");
    step4(1'b1, 4'd1, 4'd1, 8'd1, 1'b0, "1x1_e1");
    step4(1'b1, 4'd1, 4'd1, 8'd1, 1'b0, "1x1_e2");
    step4(1'b1, 4'd1, 4'd1, 8'd1, 1'b0, "1x1_e3");
    step4(1'b1, 4'd1, 4'd1, 8'd1, 1'b1, "1x1_e4");
    step4(1'b1, 4'd1, 4'd1, 8'd1, 1'b1, "1x1_hold");

    // 2 x 2 partial sums: 0, 4, 4, 4.
    step4(1'b0, 4'd2, 4'd2, 8'd0, 1'b0, "load_2x2");
    step4(1'b1, 4'd2, 4'd2, 8'd0, 1'b0, "2x2_e1");
    step4(1'b1, 4'd2, 4'd2, 8'd4, 1'b0, "2x2_e2");
    step4(1'b1, 4'd2, 4'd2, 8'd4, 1'b0, "2x2_e3");
    step4(1'b1, 4'd2, 4'd2, 8'd4, 1'b1, "2x2_e4");

    // 3 x 2 partial sums: 0, 6, 6, 6.
    step4(1'b0, 4'd3, 4'd2, 8'd0, 1'b0, "load_3x2");
    step4(1'b1, 4'd3, 4'd2, 8'd0, 1'b0, "3x2_e1");
    step4(1'b1, 4'd3, 4'd2, 8'd6, 1'b0, "3x2_e2");
    step4(1'b1, 4'd3, 4'd2, 8'd6, 1'b0, "3x2_e3");
    step4(1'b1, 4'd3, 4'd2, 8'd6, 1'b1, "3x2_e4");

    // 15 x 14 partial sums: 0, 30, 90, 210; then held while a/b change.
    step4(1'b0, 4'd15, 4'd14, 8'd0,   1'b0, "load_15x14");
    step4(1'b1, 4'd15, 4'd14, 8'd0,   1'b0, "15x14_e1");
    step4(1'b1, 4'd15, 4'd14, 8'd30,  1'b0, "15x14_e2");
    step4(1'b1, 4'd15, 4'd14, 8'd90,  1'b0, "15x14_e3");
    step4(1'b1, 4'd15, 4'd14, 8'd210, 1'b1, "15x14_e4");
    step4(1'b1, 4'd5,  4'd3,  8'd210, 1'b1, "15x14_hold1");
    step4(1'b1, 4'd9,  4'd7,  8'd210, 1'b1, "15x14_hold2");
    step4(1'b1, 4'd0,  4'd0,  8'd210, 1'b1, "15x14_hold3");

    // Abort 15 x 14 after two edges, restart as 5 x 3 (sums 5, 15, 15, 15).
    step4(1'b0, 4'd15, 4'd14, 8'd0,  1'b0, "load_abort");
    step4(1'b1, 4'd15, 4'd14, 8'd0,  1'b0, "abort_e1");
    step4(1'b1, 4'd15, 4'd14, 8'd30, 1'b0, "abort_e2");
    step4(1'b0, 4'd5,  4'd3,  8'd0,  1'b0, "abort_reload");
    step4(1'b1, 4'd5,  4'd3,  8'd5,  1'b0, "5x3_e1");
    step4(1'b1, 4'd5,  4'd3,  8'd15, 1'b0, "5x3_e2");
    step4(1'b1, 4'd5,  4'd3,  8'd15, 1'b0, "5x3_e3");
    step4(1'b1, 4'd5,  4'd3,  8'd15, 1'b1, "5x3_e4");

    // Zero multiplicand: p stays 0, done still after four edges.
    step4(1'b0, 4'd0, 4'd9, 8'd0, 1'b0, "load_0x9");
    step4(1'b1, 4'd0, 4'd9, 8'd0, 1'b0, "0x9_e1");
    step4(1'b1, 4'd0, 4'd9, 8'd0, 1'b0, "0x9_e2");
    step4(1'b1, 4'd0, 4'd9, 8'd0, 1'b0, "0x9_e3");
    step4(1'b1, 4'd0, 4'd9, 8'd0, 1'b1, "0x9_e4");

    // Reset mid-run, then en stays high: zeroed operands are multiplied.
    step4(1'b0, 4'd7, 4'd3, 8'd0, 1'b0, "load_7x3");
    step4(1'b1, 4'd7, 4'd3, 8'd7, 1'b0, "7x3_e1");
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    x.wide = 1'b0; x.p = 16'd0; x.done = 1'b0; x.nm = "midrun_reset";
    exp_q.push_back(x);
    step4(1'b1, 4'd7, 4'd3, 8'd0, 1'b0, "postrst_e1");
    step4(1'b1, 4'd7, 4'd3, 8'd0, 1'b0, "postrst_e2");
    step4(1'b1, 4'd7, 4'd3, 8'd0, 1'b0, "postrst_e3");
    step4(1'b1, 4'd7, 4'd3, 8'd0, 1'b1, "postrst_e4");

    // 8-bit instance: 255 x 255, done only on the eighth edge.
    step8(1'b0, 8'd255, 8'd255, 16'd0, 1'b0, "n8_load");
    for (int k = 0; k < 8; k++) begin
      step8(1'b1, 8'd255, 8'd255, wide_exp[k], (k == 7) ? 1'b1 : 1'b0,
            $sformatf("n8_e%0d", k + 1));
    end
    step8(1'b1, 8'd3, 8'd3, 16'd65025, 1'b1, "n8_hold");

    // Drain the scoreboard; anything left unchecked is a failure.
    repeat (3) @(negedge clk);
    #1;
    if (exp_q.size() != 0) begin
      n_bad = n_bad + exp_q.size();
      $display("FAIL drain: got %0d unchecked entries, want 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
